// File: rtl/chan_pkt_arbiter.sv
// Packet-level round-robin merge of two stream sources, tagging each beat with its source id; CHAN_ARB_TIMEOUT_EN adds forced close of stalled packets.
// One-cycle registered latency at full throughput; the granted source sees ready whenever the output register is empty or draining.
module chan_pkt_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int USER_WIDTH     = 16,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic                  s0_tvalid,
  output logic                  s0_tready,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic [USER_WIDTH-1:0] s0_tuser,
  input  logic                  s0_tlast,
  input  logic                  s1_tvalid,
  output logic                  s1_tready,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic [USER_WIDTH-1:0] s1_tuser,
  input  logic                  s1_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic                  m_tlast,
  output logic                  m_tid,
  output logic [1:0]            status_grant,
  output logic                  status_idle,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_1,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
    logic                  tid;
  } beat_t;

  state_t state, end_state;
  logic   last_grant;
  beat_t  in_beat, out_q;
  logic   gnt_id, out_free, acc, acc_last, cur_vld, other_vld;
  logic   to_pend, to_fire, pkt_end;

  assign gnt_id    = (state == GNT1);
  assign out_free  = !m_tvalid || m_tready;
  // A pending forced close owns the next output slot, so the source is held off.
  assign s0_tready = (state == GNT0) && out_free && !to_pend;
  assign s1_tready = (state == GNT1) && out_free && !to_pend;
  assign acc       = (s0_tvalid && s0_tready) || (s1_tvalid && s1_tready);
  assign cur_vld   = gnt_id ? s1_tvalid : s0_tvalid;
  assign other_vld = gnt_id ? s0_tvalid : s1_tvalid;

  always_comb begin
    in_beat = '0;
    if (to_fire) begin
      in_beat.tlast = 1'b1;
      in_beat.tid   = gnt_id;
    end else if (gnt_id) begin
      in_beat = {s1_tdata, s1_tuser, s1_tlast, 1'b1};
    end else begin
      in_beat = {s0_tdata, s0_tuser, s0_tlast, 1'b0};
    end
  end

  assign acc_last = acc && in_beat.tlast;
  assign pkt_end  = acc_last || to_fire;

  // Round robin at packet end: the other source first, else keep the current one.
  always_comb begin
    end_state = IDLE;
    if (cfg_enable && other_vld)
      end_state = gnt_id ? GNT0 : GNT1;
    else if (cfg_enable && cur_vld)
      end_state = gnt_id ? GNT1 : GNT0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      out_q      <= '0;
      m_tvalid   <= 1'b0;
      pkt_cnt_0  <= '0;
      pkt_cnt_1  <= '0;
    end else begin
      if (acc || to_fire) begin
        out_q    <= in_beat;
        m_tvalid <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      if (acc_last && !gnt_id) pkt_cnt_0 <= pkt_cnt_0 + 1'b1;
      if (acc_last && gnt_id)  pkt_cnt_1 <= pkt_cnt_1 + 1'b1;

      case (state)
        IDLE: begin
          if (cfg_enable && (s0_tvalid || s1_tvalid))
            state <= (s0_tvalid && (!s1_tvalid || last_grant)) ? GNT0 : GNT1;
        end
        default: begin
          if (pkt_end) begin
            state      <= end_state;
            last_grant <= gnt_id;
          end
        end
      endcase
    end
  end

`ifdef CHAN_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] stall_cnt;

  assign to_pend = (stall_cnt == TO_W'(TIMEOUT_CYCLES));
  assign to_fire = to_pend && out_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_fire;
      if (state == IDLE || acc || to_fire)
        stall_cnt <= '0;
      else if (!cur_vld && !to_pend)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign to_pend     = 1'b0;
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign m_tdata      = out_q.tdata;
  assign m_tuser      = out_q.tuser;
  assign m_tlast      = out_q.tlast;
  assign m_tid        = out_q.tid;
  assign status_grant = {state == GNT1, state == GNT0};
  assign status_idle  = (state == IDLE) && !m_tvalid;

endmodule

// File: tb/tb_chan_pkt_arbiter.sv
// Scoreboard bench for chan_pkt_arbiter: per-source expected beat queues plus expected packet-source order.
`timescale 1ns/1ps
module tb_chan_pkt_arbiter;
  localparam int DW = 32;
  localparam int UW = 16;
  localparam int CW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_enable;
  logic          s0_tvalid, s0_tready, s0_tlast;
  logic [DW-1:0] s0_tdata;
  logic [UW-1:0] s0_tuser;
  logic          s1_tvalid, s1_tready, s1_tlast;
  logic [DW-1:0] s1_tdata;
  logic [UW-1:0] s1_tuser;
  logic          m_tvalid, m_tready, m_tlast, m_tid;
  logic [DW-1:0] m_tdata;
  logic [UW-1:0] m_tuser;
  logic [1:0]    status_grant;
  logic          status_idle, timeout_err;
  logic [CW-1:0] pkt_cnt_0, pkt_cnt_1;

  always #5 clk = ~clk;

  chan_pkt_arbiter #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata),
    .s0_tuser(s0_tuser), .s0_tlast(s0_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata),
    .s1_tuser(s1_tuser), .s1_tlast(s1_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tid(m_tid),
    .status_grant(status_grant), .status_idle(status_idle),
    .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  beat_t src_q0[$], src_q1[$], exp_q0[$], exp_q1[$];
  logic  exp_tid_q[$];
  int    cyc, start0, start1;
  int    n_checks, n_pass;
  logic  tog_mode, drop_arm;
  logic [CW-1:0] exp_cnt0, exp_cnt1;
  int    first_out, last_out, n_out, to_pulses, s1_acc, t_a2, t_z;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic monitor();
    beat_t got, exp;
    if (timeout_err) to_pulses++;
    if (m_tvalid) begin
      got = {m_tdata, m_tuser, m_tlast};
      if ((m_tid ? exp_q1.size() : exp_q0.size()) == 0 || exp_tid_q.size() == 0) begin
        check("unexpected_beat", {63'b0, m_tvalid}, 64'd0);
      end else begin
        exp = m_tid ? exp_q1[0] : exp_q0[0];
        check("beat_dat", got, exp);
        check("beat_tid", {63'b0, m_tid}, {63'b0, exp_tid_q[0]});
        if (m_tready) begin
          if (m_tid) exp_q1.delete(0); else exp_q0.delete(0);
          if (exp.last) exp_tid_q.delete(0);
          n_out++;
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
          if (!m_tid && m_tdata == 32'hA2) t_a2 = cyc;
          if (!m_tid && m_tlast && m_tdata == '0) t_z = cyc;
        end
      end
    end
  endtask

  task automatic drive();
    s0_tvalid = (cyc >= start0) && (src_q0.size() > 0);
    s1_tvalid = (cyc >= start1) && (src_q1.size() > 0);
    if (src_q0.size() > 0) {s0_tdata, s0_tuser, s0_tlast} = src_q0[0];
    else {s0_tdata, s0_tuser, s0_tlast} = '0;
    if (src_q1.size() > 0) {s1_tdata, s1_tuser, s1_tlast} = src_q1[0];
    else {s1_tdata, s1_tuser, s1_tlast} = '0;
    m_tready = tog_mode ? !m_tready : 1'b1;
  endtask

  task automatic step();
    logic h0, h1;
    @(negedge clk);
    monitor();
    h0 = s0_tvalid && s0_tready;
    h1 = s1_tvalid && s1_tready;
    @(posedge clk);
    #1;
    cyc++;
    if (h0) src_q0.delete(0);
    if (h1) begin
      src_q1.delete(0);
      s1_acc++;
      if (drop_arm && s1_acc == 2) cfg_enable = 1'b0;
    end
    drive();
  endtask

  task automatic push_pkt(input logic src, input int len, input int base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = DW'(base + i);
      b.user = UW'(16'h100 * (src ? 2 : 1) + base + i);
      b.last = (i == len - 1);
      if (src) begin src_q1.push_back(b); exp_q1.push_back(b); end
      else begin src_q0.push_back(b); exp_q0.push_back(b); end
    end
    if (src) exp_cnt1++; else exp_cnt0++;
  endtask

  task automatic drain(input string tag, input logic full, input int budget);
    int n;
    n = 0;
    while (n < budget && (full ? (src_q0.size() + src_q1.size() + exp_q0.size() + exp_q1.size() != 0)
                               : (src_q1.size() + exp_q1.size() != 0))) begin
      step();
      n++;
    end
    check(tag, {63'b0, n < budget}, 64'd1);
    repeat (3) step();
  endtask

  task automatic new_test();
    first_out = -1;
    last_out  = -1;
    n_out     = 0;
  endtask

  initial begin
    int c;
    logic [CW-1:0] need;
    beat_t b;
    n_checks = 0; n_pass = 0; cyc = 0; start0 = 0; start1 = 0;
    exp_cnt0 = '0; exp_cnt1 = '0; to_pulses = 0; s1_acc = 0; t_a2 = 0; t_z = 0;
    tog_mode = 1'b0; drop_arm = 1'b0; cfg_enable = 1'b1;
    rst = 1'b1;
    m_tready = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_idle",  {63'b0, status_idle}, 64'd1);
    check("rst_grant", {62'b0, status_grant}, 64'd0);
    check("rst_mvld",  {63'b0, m_tvalid}, 64'd0);
    check("rst_rdy",   {62'b0, s1_tready, s0_tready}, 64'd0);
    check("rst_out",   {m_tdata, m_tuser, m_tlast, m_tid}, 64'd0);
    check("rst_cnt",   {56'b0, pkt_cnt_1, pkt_cnt_0}, 64'd0);
    check("rst_toerr", {63'b0, timeout_err}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();

    // single 4-beat packet from s0
    new_test();
    c = cyc; start0 = cyc;
    push_pkt(1'b0, 4, 1); exp_tid_q.push_back(1'b0);
    drive();
    drain("t1_drain", 1'b1, 50);
    check("t1_latency", 64'(first_out - c), 64'd2);
    check("t1_span", 64'(last_out - first_out), 64'd3);
    check("t1_cnt0", {60'b0, pkt_cnt_0}, {60'b0, exp_cnt0});

    // both sources busy, full throughput
    new_test();
    start0 = cyc; start1 = cyc + 1;
    for (int p = 0; p < 3; p++) begin
      push_pkt(1'b0, 3, 16 + 8 * p);
      push_pkt(1'b1, 3, 64 + 8 * p);
      exp_tid_q.push_back(1'b0);
      exp_tid_q.push_back(1'b1);
    end
    drive();
    drain("t2_drain", 1'b1, 100);
    check("t2_beats", 64'(n_out), 64'd18);
    check("t2_no_bubble", 64'(last_out - first_out), 64'(n_out - 1));

    // same with downstream ready toggling every cycle
    new_test();
    tog_mode = 1'b1;
    start1 = cyc; start0 = cyc + 1;
    for (int p = 0; p < 3; p++) begin
      push_pkt(1'b1, 3, 128 + 8 * p);
      exp_tid_q.push_back(1'b1);
      if (p < 2) begin
        push_pkt(1'b0, 3, 192 + 8 * p);
        exp_tid_q.push_back(1'b0);
      end
    end
    drive();
    drain("t3_drain", 1'b1, 200);
    check("t3_beats", 64'(n_out), 64'd15);
    tog_mode = 1'b0;

    // enable dropped mid-packet on s1 while s0 waits
    new_test();
    s1_acc = 0; drop_arm = 1'b1;
    start1 = cyc; start0 = cyc + 1;
    push_pkt(1'b1, 5, 256); exp_tid_q.push_back(1'b1);
    push_pkt(1'b0, 3, 320); exp_tid_q.push_back(1'b0);
    drive();
    drain("t4_s1_drain", 1'b0, 60);
    check("t4_idle", {63'b0, status_idle}, 64'd1);
    check("t4_grant", {62'b0, status_grant}, 64'd0);
    check("t4_rdy", {62'b0, s1_tready, s0_tready}, 64'd0);
    check("t4_s0_held", 64'(src_q0.size()), 64'd3);
    drop_arm = 1'b0;
    cfg_enable = 1'b1;
    drain("t4_drain", 1'b1, 60);
    check("t4_cnt1", {60'b0, pkt_cnt_1}, {60'b0, exp_cnt1});

    // s0 counter to all-ones, then wrap
    new_test();
    start0 = cyc;
    need = 4'd15 - exp_cnt0;
    for (int p = 0; p < int'(need); p++) begin
      push_pkt(1'b0, 1, 400 + p); exp_tid_q.push_back(1'b0);
    end
    drive();
    drain("t5_drain", 1'b1, 100);
    check("t5_cnt_allones", {60'b0, pkt_cnt_0}, {60'b0, exp_cnt0});
    push_pkt(1'b0, 1, 500); exp_tid_q.push_back(1'b0);
    drive();
    drain("t5_drain2", 1'b1, 20);
    check("t5_cnt_wrap", {60'b0, pkt_cnt_0}, {60'b0, exp_cnt0});

`ifdef CHAN_ARB_TIMEOUT_EN
    // s0 stalls after 2 beats of 4; forced close then s1 is granted
    new_test();
    to_pulses = 0;
    start0 = cyc; start1 = cyc + 1;
    b = {32'hA1, 16'h00A1, 1'b0}; src_q0.push_back(b); exp_q0.push_back(b);
    b = {32'hA2, 16'h00A2, 1'b0}; src_q0.push_back(b); exp_q0.push_back(b);
    b = '0; b.last = 1'b1; exp_q0.push_back(b);
    exp_tid_q.push_back(1'b0);
    push_pkt(1'b1, 2, 600); exp_tid_q.push_back(1'b1);
    drive();
    drain("t6_drain", 1'b1, 200);
    check("t6_pulses", 64'(to_pulses), 64'd1);
    check("t6_gap", {63'b0, (t_z - t_a2 >= 16) && (t_z - t_a2 <= 18)}, 64'd1);
    check("t6_cnt0", {60'b0, pkt_cnt_0}, {60'b0, exp_cnt0});
`else
    check("no_timeout_pulse", 64'(to_pulses), 64'd0);
`endif
    check("end_cnt1", {60'b0, pkt_cnt_1}, {60'b0, exp_cnt1});
    check("end_tid_q", 64'(exp_tid_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
